// File: rtl/button_events_pkg.sv
// button_events_pkg
// Shared definitions for the button event detector:
//   - state_e  : per-channel FSM state encoding (IDLE=0, SHORT=1, LONG=2)
//   - max_int  : constant helper used to size the per-channel counters
package button_events_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/button_events_channel.sv
// button_events_channel
// One independent button channel: previous-sample register, IDLE/SHORT/LONG
// FSM, cycle counter and registered event outputs.
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   din          in   debounced button level
//   press_pulse  out  one cycle after a press edge
//   short_pulse  out  one cycle after a release before the long threshold
//   long_pulse   out  one cycle when the long threshold is reached
//   repeat_pulse out  one cycle every REPEAT_CNT cycles while long-held
//   held         out  high while in LONG
module button_events_channel
  import button_events_pkg::*;
#(
  parameter int LONG_CNT   = 25000000,
  parameter int REPEAT_CNT = 5000000,
  parameter int CNT_WIDTH  = $clog2(max_int(LONG_CNT, REPEAT_CNT)) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  // Counter value seen on the edge that completes each interval; the counter
  // is cleared on entry, so N cycles elapse when it reads N-1.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST =
    CNT_WIDTH'((REPEAT_CNT > 0) ? (REPEAT_CNT - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam bit                   REPEAT_EN   = (REPEAT_CNT > 0);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 prev_q, prev_d;
  logic                 press_q, press_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
  logic                 repeat_q, repeat_d;
  logic                 held_q, held_d;

  // Next-state, counter and output decode for the channel FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = din;
    press_d  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A level that was already high (e.g. held through reset) is ignored
        // until it has been seen low.
        if (din && !prev_q) begin
          state_d = ST_SHORT;
          cnt_d   = CNT_ZERO;
          press_d = 1'b1;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_SHORT: begin
        // Release wins over the threshold on the very edge it is reached.
        if (!din) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          short_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          cnt_d   = CNT_ZERO;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (!din) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
          cnt_d    = CNT_ZERO;
          repeat_d = 1'b1;
        end else if (REPEAT_EN) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          // Repeat disabled: counter parks at zero so it can never wrap.
          cnt_d = CNT_ZERO;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    held_d = (state_d == ST_LONG);
  end

  // State, counter, sample and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      prev_q   <= 1'b1;
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign press_pulse  = press_q;
  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign held         = held_q;

endmodule

// File: rtl/button_events.sv
// button_events
// WIDTH independent button event detectors (press / short / long / repeat /
// held), one button_events_channel per bit.
// Ports:
//   clk              in   sole clock, rising edge
//   rst              in   asynchronous active-high reset
//   debounced_signal in   [WIDTH] debounced button levels
//   press_pulse      out  [WIDTH] press event pulses
//   short_pulse      out  [WIDTH] short-press release pulses
//   long_pulse       out  [WIDTH] long-press threshold pulses
//   repeat_pulse     out  [WIDTH] auto-repeat pulses while long-held
//   held             out  [WIDTH] long-hold level
module button_events
  import button_events_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int LONG_CNT   = 25000000,
  parameter int REPEAT_CNT = 5000000,
  parameter int CNT_WIDTH  = $clog2(max_int(LONG_CNT, REPEAT_CNT)) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] short_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic [WIDTH-1:0] held
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_events_channel #(
      .LONG_CNT  (LONG_CNT),
      .REPEAT_CNT(REPEAT_CNT),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .din         (debounced_signal[i]),
      .press_pulse (press_pulse[i]),
      .short_pulse (short_pulse[i]),
      .long_pulse  (long_pulse[i]),
      .repeat_pulse(repeat_pulse[i]),
      .held        (held[i])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events
// Directed bench: u_dut_a (WIDTH=2, LONG_CNT=8, REPEAT_CNT=4) and
// u_dut_b (WIDTH=1, LONG_CNT=8, REPEAT_CNT=0). Outputs are packed per channel
// as {press, short, long, repeat, held} and checked 1 time unit after each
// rising edge against hand-computed vectors.
module tb_button_events;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] P    = 5'b10000;
  localparam logic [4:0] S    = 5'b01000;
  localparam logic [4:0] L    = 5'b00100;
  localparam logic [4:0] R    = 5'b00010;
  localparam logic [4:0] H    = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] din_a = 2'b00;
  logic [0:0] din_b = 1'b0;

  logic [1:0] press_a, short_a, long_a, rep_a, held_a;
  logic [0:0] press_b, short_b, long_b, rep_b, held_b;
  logic [4:0] v0, v1, vb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_events #(.WIDTH(2), .LONG_CNT(8), .REPEAT_CNT(4)) u_dut_a (
    .clk(clk), .rst(rst), .debounced_signal(din_a),
    .press_pulse(press_a), .short_pulse(short_a), .long_pulse(long_a),
    .repeat_pulse(rep_a), .held(held_a)
  );

  button_events #(.WIDTH(1), .LONG_CNT(8), .REPEAT_CNT(0)) u_dut_b (
    .clk(clk), .rst(rst), .debounced_signal(din_b),
    .press_pulse(press_b), .short_pulse(short_b), .long_pulse(long_b),
    .repeat_pulse(rep_b), .held(held_b)
  );

  assign v0 = {press_a[0], short_a[0], long_a[0], rep_a[0], held_a[0]};
  assign v1 = {press_a[1], short_a[1], long_a[1], rep_a[1], held_a[1]};
  assign vb = {press_b[0], short_b[0], long_b[0], rep_b[0], held_b[0]};

  task automatic check_vec(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (press,short,long,repeat,held) t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs, let one rising edge sample them, then check all channels.
  task automatic step(input logic [1:0] da, input logic db, input logic [4:0] e0,
                      input logic [4:0] e1, input logic [4:0] eb, input string tag);
    din_a = da;
    din_b = db;
    @(posedge clk);
    #1;
    check_vec({tag, "/ch0"}, v0, e0);
    check_vec({tag, "/ch1"}, v1, e1);
    check_vec({tag, "/b"}, vb, eb);
  endtask

  initial begin
    logic [4:0] e0;
    logic [4:0] e1;
    logic [4:0] eb;

    // Reset with ch0 already high.
    din_a = 2'b01;
    #2 rst = 1'b1;
    #1;
    check_vec("reset_async/ch0", v0, NONE);
    check_vec("reset_async/ch1", v1, NONE);
    check_vec("reset_async/b", vb, NONE);
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset/ch0", v0, NONE);
    check_vec("reset/b", vb, NONE);
    rst = 1'b0;

    // Held through reset release: no press for 20 cycles.
    for (int i = 0; i < 20; i++) step(2'b01, 1'b0, NONE, NONE, NONE, "held_thru_rst");
    step(2'b00, 1'b0, NONE, NONE, NONE, "low_after_rst");

    // Short press: high t0..t0+2, low at t0+3.
    for (int i = 0; i <= 5; i++) begin
      e0 = (i == 0) ? P : ((i == 3) ? S : NONE);
      step((i < 3) ? 2'b01 : 2'b00, 1'b0, e0, NONE, NONE, "short");
    end

    // Long press with repeats: high t0..t0+19, low at t0+20.
    for (int i = 0; i <= 22; i++) begin
      e0 = NONE;
      if (i == 0) e0 = P;
      else if (i == 8) e0 = L | H;
      else if (i == 12 || i == 16) e0 = R | H;
      else if (i > 8 && i < 20) e0 = H;
      step((i < 20) ? 2'b01 : 2'b00, 1'b0, e0, NONE, NONE, "long_rep");
    end

    // Release exactly at the long threshold edge is still a short press.
    for (int i = 0; i <= 10; i++) begin
      e0 = (i == 0) ? P : ((i == 8) ? S : NONE);
      step((i < 8) ? 2'b01 : 2'b00, 1'b0, e0, NONE, NONE, "short_at_thresh");
    end

    // Press on the edge right after a release restarts normally.
    step(2'b01, 1'b0, P, NONE, NONE, "b2b_p1");
    step(2'b00, 1'b0, S, NONE, NONE, "b2b_s1");
    step(2'b01, 1'b0, P, NONE, NONE, "b2b_p2");
    step(2'b00, 1'b0, S, NONE, NONE, "b2b_s2");
    step(2'b00, 1'b0, NONE, NONE, NONE, "b2b_idle");

    // ch0 long-held (released on a repeat edge) while ch1 does a short press.
    for (int i = 0; i <= 18; i++) begin
      e0 = NONE;
      e1 = NONE;
      if (i == 0) e0 = P;
      else if (i == 8) e0 = L | H;
      else if (i == 12) e0 = R | H;
      else if (i > 8 && i < 16) e0 = H;
      if (i == 11) e1 = P;
      else if (i == 14) e1 = S;
      step({(i >= 11 && i <= 13), (i <= 15)}, 1'b0, e0, e1, NONE, "indep");
    end

    // Reset mid-LONG: outputs clear at once; later release gives nothing.
    for (int i = 0; i <= 9; i++) begin
      e0 = NONE;
      if (i == 0) e0 = P;
      else if (i == 8) e0 = L | H;
      else if (i == 9) e0 = H;
      step(2'b01, 1'b0, e0, NONE, NONE, "pre_rst");
    end
    #2 rst = 1'b1;
    #1;
    check_vec("mid_long_rst/ch0", v0, NONE);
    check_vec("mid_long_rst/ch1", v1, NONE);
    @(posedge clk);
    #1;
    check_vec("mid_long_rst_edge/ch0", v0, NONE);
    rst = 1'b0;
    step(2'b01, 1'b0, NONE, NONE, NONE, "post_rst_hold");
    step(2'b01, 1'b0, NONE, NONE, NONE, "post_rst_hold");
    step(2'b00, 1'b0, NONE, NONE, NONE, "post_rst_release");
    step(2'b00, 1'b0, NONE, NONE, NONE, "post_rst_idle");

    // Repeat disabled: held 30 cycles, long+held, never a repeat pulse.
    for (int i = 0; i <= 32; i++) begin
      eb = NONE;
      if (i == 0) eb = P;
      else if (i == 8) eb = L | H;
      else if (i > 8 && i < 30) eb = H;
      step(2'b00, (i < 30), NONE, NONE, eb, "norep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
